axim_outstanding_limiter: RTL and testbench

Transaction-credit limiter for an AXI4 memory-mapped path. It passes all five channels through and bounds the number of outstanding read bursts (AR accepted, final R beat not yet returned) and write bursts (AW accepted, B not yet returned). It sits directly upstream of the AXI4 register slice and throttles AR/AW issue into the slice so downstream interconnect and memory queues cannot be oversubscribed. It also exports live occupancy, stall statistics and a sticky protocol-error flag.

---
 rtl/axim_outstanding_limiter_pkg.sv | 30 +++
 rtl/axim_outstanding_limiter_credit_cnt.sv | 49 ++++
 rtl/axim_outstanding_limiter.sv | 190 +++++++++++++++++++
 tb/tb_axim_outstanding_limiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axim_outstanding_limiter_pkg.sv
// Shared constants and credit-update helpers for the AXI outstanding-transaction limiter.
package axim_outstanding_limiter_pkg;

    localparam int AXI_OUTSTANDING_DEF = 8;
    localparam int OUTSTANDING_BITS    = 8;
    localparam int AXI_ID_W            = 4;
    localparam int AXI_ADDR_W          = 32;
    localparam int AXI_DATA_W          = 64;

    typedef enum logic [1:0] {
        CR_HOLD      = 2'd0,
        CR_INC       = 2'd1,
        CR_DEC       = 2'd2,
        CR_UNDERFLOW = 2'd3
    } credit_op_e;

    // Simultaneous issue and completion cancel out, even at zero or full.
    function automatic credit_op_e credit_op(input logic inc, input logic dec,
                                             input logic empty, input logic full);
        credit_op_e op;
        op = CR_HOLD;
        if (inc && !dec && !full) begin
            op = CR_INC;
        end else if (dec && !inc) begin
            op = empty ? CR_UNDERFLOW : CR_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/axim_outstanding_limiter_credit_cnt.sv
// Per-direction credit tracker: saturating in-flight count, full flag,
// wrapping stall counter and a single-cycle underflow pulse.
module axi_credit_cnt
    import axim_outstanding_limiter_pkg::*;
#(
    parameter int MAX = AXI_OUTSTANDING_DEF
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        inc,
    input  logic                        dec,
    input  logic                        req_pending,
    output logic [OUTSTANDING_BITS-1:0] cnt,
    output logic                        full,
    output logic [31:0]                 stall_cycles,
    output logic                        underflow
);

    localparam logic [OUTSTANDING_BITS-1:0] MAX_CNT = OUTSTANDING_BITS'(MAX);
    localparam logic [OUTSTANDING_BITS-1:0] ONE     = OUTSTANDING_BITS'(1);

    credit_op_e op;

    // cnt is held at 0 in reset and MAX >= 1, so full is low during reset.
    assign full      = (cnt == MAX_CNT);
    assign op        = credit_op(inc, dec, (cnt == '0), full);
    assign underflow = (op == CR_UNDERFLOW);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else begin
            case (op)
                CR_INC:  cnt <= cnt + ONE;
                CR_DEC:  cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cycles <= '0;
        end else if (req_pending && full) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: rtl/axim_outstanding_limiter.sv
// AXI4 passthrough that caps in-flight read and write bursts by gating AR/AW
// issue, and reports occupancy, stall statistics and a sticky underflow flag.
module axim_outstanding_limiter
    import axim_outstanding_limiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING_RD = AXI_OUTSTANDING_DEF,
    parameter int MAX_OUTSTANDING_WR = AXI_OUTSTANDING_DEF,
    parameter int ID_W               = AXI_ID_W,
    parameter int ADDR_W             = AXI_ADDR_W,
    parameter int DATA_W             = AXI_DATA_W
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    // upstream AR
    input  logic [ID_W-1:0]             s_axi_arid,
    input  logic [ADDR_W-1:0]           s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arlock,
    input  logic [3:0]                  s_axi_arcache,
    input  logic [2:0]                  s_axi_arprot,
    input  logic [3:0]                  s_axi_arqos,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    // upstream AW
    input  logic [ID_W-1:0]             s_axi_awid,
    input  logic [ADDR_W-1:0]           s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awlock,
    input  logic [3:0]                  s_axi_awcache,
    input  logic [2:0]                  s_axi_awprot,
    input  logic [3:0]                  s_axi_awqos,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    // upstream W
    input  logic [DATA_W-1:0]           s_axi_wdata,
    input  logic [DATA_W/8-1:0]         s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    // upstream R
    output logic [ID_W-1:0]             s_axi_rid,
    output logic [DATA_W-1:0]           s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    // upstream B
    output logic [ID_W-1:0]             s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    // downstream AR
    output logic [ID_W-1:0]             m_axi_arid,
    output logic [ADDR_W-1:0]           m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic [3:0]                  m_axi_arqos,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    // downstream AW
    output logic [ID_W-1:0]             m_axi_awid,
    output logic [ADDR_W-1:0]           m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awqos,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    // downstream W
    output logic [DATA_W-1:0]           m_axi_wdata,
    output logic [DATA_W/8-1:0]         m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    // downstream R
    input  logic [ID_W-1:0]             m_axi_rid,
    input  logic [DATA_W-1:0]           m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    // downstream B
    input  logic [ID_W-1:0]             m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    // status
    output logic [OUTSTANDING_BITS-1:0] rd_outstanding,
    output logic [OUTSTANDING_BITS-1:0] wr_outstanding,
    output logic [31:0]                 rd_stall_cycles,
    output logic [31:0]                 wr_stall_cycles,
    output logic                        err_underflow
);

    logic rd_full, wr_full;
    logic rd_inc, rd_dec, wr_inc, wr_dec;
    logic rd_underflow, wr_underflow;

    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arqos   = s_axi_arqos;
    assign m_axi_arvalid = s_axi_arvalid & ~rd_full;
    assign s_axi_arready = m_axi_arready & ~rd_full;

    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awqos   = s_axi_awqos;
    assign m_axi_awvalid = s_axi_awvalid & ~wr_full;
    assign s_axi_awready = m_axi_awready & ~wr_full;

    // W is deliberately ungated: AXI4 allows write data ahead of its address.
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;
    assign m_axi_wvalid  = s_axi_wvalid;
    assign s_axi_wready  = m_axi_wready;

    assign s_axi_rid     = m_axi_rid;
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rresp   = m_axi_rresp;
    assign s_axi_rlast   = m_axi_rlast;
    assign s_axi_rvalid  = m_axi_rvalid;
    assign m_axi_rready  = s_axi_rready;

    assign s_axi_bid     = m_axi_bid;
    assign s_axi_bresp   = m_axi_bresp;
    assign s_axi_bvalid  = m_axi_bvalid;
    assign m_axi_bready  = s_axi_bready;

    assign rd_inc = m_axi_arvalid & m_axi_arready;
    assign rd_dec = m_axi_rvalid & s_axi_rready & m_axi_rlast;
    assign wr_inc = m_axi_awvalid & m_axi_awready;
    assign wr_dec = m_axi_bvalid & s_axi_bready;

    axi_credit_cnt #(.MAX(MAX_OUTSTANDING_RD)) u_rd_credit (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inc          (rd_inc),
        .dec          (rd_dec),
        .req_pending  (s_axi_arvalid),
        .cnt          (rd_outstanding),
        .full         (rd_full),
        .stall_cycles (rd_stall_cycles),
        .underflow    (rd_underflow)
    );

    axi_credit_cnt #(.MAX(MAX_OUTSTANDING_WR)) u_wr_credit (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inc          (wr_inc),
        .dec          (wr_dec),
        .req_pending  (s_axi_awvalid),
        .cnt          (wr_outstanding),
        .full         (wr_full),
        .stall_cycles (wr_stall_cycles),
        .underflow    (wr_underflow)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_underflow <= 1'b0;
        end else if (rd_underflow || wr_underflow) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axim_outstanding_limiter.sv
// Directed bench: u_dut runs with MAX_RD=4 / MAX_WR=1, u_def with default limits.
module tb_axim_outstanding_limiter;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [3:0]  s_axi_arid, s_axi_awid, m_axi_rid, m_axi_bid;
    logic [31:0] s_axi_araddr, s_axi_awaddr;
    logic [7:0]  s_axi_arlen, s_axi_awlen;
    logic [2:0]  s_axi_arsize, s_axi_awsize, s_axi_arprot, s_axi_awprot;
    logic [1:0]  s_axi_arburst, s_axi_awburst, m_axi_rresp, m_axi_bresp;
    logic        s_axi_arlock, s_axi_awlock;
    logic [3:0]  s_axi_arcache, s_axi_awcache, s_axi_arqos, s_axi_awqos;
    logic        s_axi_arvalid, s_axi_awvalid, m_axi_arready, m_axi_awready;
    logic [63:0] s_axi_wdata, m_axi_rdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, m_axi_wready;
    logic        m_axi_rlast, m_axi_rvalid, s_axi_rready;
    logic        m_axi_bvalid, s_axi_bready;

    // u_dut outputs
    logic        s_axi_arready, s_axi_awready, s_axi_wready;
    logic [3:0]  s_axi_rid, s_axi_bid, m_axi_arid, m_axi_awid;
    logic [63:0] s_axi_rdata, m_axi_wdata;
    logic [1:0]  s_axi_rresp, s_axi_bresp, m_axi_arburst, m_axi_awburst;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_bvalid;
    logic [31:0] m_axi_araddr, m_axi_awaddr;
    logic [7:0]  m_axi_arlen, m_axi_awlen, m_axi_wstrb;
    logic [2:0]  m_axi_arsize, m_axi_awsize, m_axi_arprot, m_axi_awprot;
    logic        m_axi_arlock, m_axi_awlock;
    logic [3:0]  m_axi_arcache, m_axi_awcache, m_axi_arqos, m_axi_awqos;
    logic        m_axi_arvalid, m_axi_awvalid, m_axi_wlast, m_axi_wvalid;
    logic        m_axi_rready, m_axi_bready;
    logic [7:0]  rd_outstanding, wr_outstanding;
    logic [31:0] rd_stall_cycles, wr_stall_cycles;
    logic        err_underflow;

    // u_def outputs
    logic        d2_s_arready, d2_s_awready, d2_s_wready;
    logic [3:0]  d2_s_rid, d2_s_bid, d2_m_arid, d2_m_awid;
    logic [63:0] d2_s_rdata, d2_m_wdata;
    logic [1:0]  d2_s_rresp, d2_s_bresp, d2_m_arburst, d2_m_awburst;
    logic        d2_s_rlast, d2_s_rvalid, d2_s_bvalid;
    logic [31:0] d2_m_araddr, d2_m_awaddr;
    logic [7:0]  d2_m_arlen, d2_m_awlen, d2_m_wstrb;
    logic [2:0]  d2_m_arsize, d2_m_awsize, d2_m_arprot, d2_m_awprot;
    logic        d2_m_arlock, d2_m_awlock;
    logic [3:0]  d2_m_arcache, d2_m_awcache, d2_m_arqos, d2_m_awqos;
    logic        d2_m_arvalid, d2_m_awvalid, d2_m_wlast, d2_m_wvalid;
    logic        d2_m_rready, d2_m_bready;
    logic [7:0]  d2_rd_out, d2_wr_out;
    logic [31:0] d2_rd_stall, d2_wr_stall;
    logic        d2_err;

    axim_outstanding_limiter #(.MAX_OUTSTANDING_RD(4), .MAX_OUTSTANDING_WR(1)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .rd_stall_cycles(rd_stall_cycles), .wr_stall_cycles(wr_stall_cycles),
        .err_underflow(err_underflow)
    );

    axim_outstanding_limiter u_def (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(d2_s_arready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(d2_s_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(d2_s_wready),
        .s_axi_rid(d2_s_rid), .s_axi_rdata(d2_s_rdata), .s_axi_rresp(d2_s_rresp),
        .s_axi_rlast(d2_s_rlast), .s_axi_rvalid(d2_s_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_bid(d2_s_bid), .s_axi_bresp(d2_s_bresp), .s_axi_bvalid(d2_s_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_axi_arid(d2_m_arid), .m_axi_araddr(d2_m_araddr), .m_axi_arlen(d2_m_arlen),
        .m_axi_arsize(d2_m_arsize), .m_axi_arburst(d2_m_arburst), .m_axi_arlock(d2_m_arlock),
        .m_axi_arcache(d2_m_arcache), .m_axi_arprot(d2_m_arprot), .m_axi_arqos(d2_m_arqos),
        .m_axi_arvalid(d2_m_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_awid(d2_m_awid), .m_axi_awaddr(d2_m_awaddr), .m_axi_awlen(d2_m_awlen),
        .m_axi_awsize(d2_m_awsize), .m_axi_awburst(d2_m_awburst), .m_axi_awlock(d2_m_awlock),
        .m_axi_awcache(d2_m_awcache), .m_axi_awprot(d2_m_awprot), .m_axi_awqos(d2_m_awqos),
        .m_axi_awvalid(d2_m_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(d2_m_wdata), .m_axi_wstrb(d2_m_wstrb), .m_axi_wlast(d2_m_wlast),
        .m_axi_wvalid(d2_m_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(d2_m_rready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(d2_m_bready),
        .rd_outstanding(d2_rd_out), .wr_outstanding(d2_wr_out),
        .rd_stall_cycles(d2_rd_stall), .wr_stall_cycles(d2_wr_stall),
        .err_underflow(d2_err)
    );

    // stim = {arvalid, m_arready, m_rvalid, m_rlast, awvalid, m_awready, wvalid, m_bvalid}
    // eo   = {m_arvalid, s_arready, m_awvalid, s_awready}; counts are pre-edge values
    typedef struct {
        logic [7:0] stim;
        logic [3:0] eo;
        int         rd;
        int         wr;
        int         rdst;
        int         wrst;
        logic       err;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t tbl[26];

    function automatic vec_t mk(input logic [7:0] stim, input logic [3:0] eo, input int rd,
                                input int wr, input int rdst, input int wrst, input logic err);
        vec_t v;
        v.stim = stim; v.eo = eo; v.rd = rd; v.wr = wr;
        v.rdst = rdst; v.wrst = wrst; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] s);
        s_axi_arvalid = s[7]; m_axi_arready = s[6];
        m_axi_rvalid  = s[5]; m_axi_rlast   = s[4];
        s_axi_awvalid = s[3]; m_axi_awready = s[2];
        s_axi_wvalid  = s[1]; m_axi_bvalid  = s[0];
    endtask

    initial begin
        int hs1;
        int hs2;
        aresetn = 1'b0;
        s_axi_arid = 4'h3; s_axi_araddr = 32'h1000_0040; s_axi_arlen = 8'd3; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = 4'h2; s_axi_arprot = 3'd0;
        s_axi_arqos = 4'h0;
        s_axi_awid = 4'h6; s_axi_awaddr = 32'h2000_0080; s_axi_awlen = 8'd3; s_axi_awsize = 3'd3;
        s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awcache = 4'h2; s_axi_awprot = 3'd0;
        s_axi_awqos = 4'h0;
        s_axi_wdata = 64'h0011_2233_4455_6677; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
        m_axi_wready = 1'b1;
        m_axi_rid = 4'h5; m_axi_rdata = 64'hDEAD_BEEF_0123_4567; m_axi_rresp = 2'b00;
        m_axi_bid = 4'h6; m_axi_bresp = 2'b10;
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        drive(8'b0000_0000);

        tbl[0]  = mk(8'b1100_0100, 4'b1101, 0, 0, 0, 0, 1'b0);
        tbl[1]  = mk(8'b1100_0100, 4'b1101, 1, 0, 0, 0, 1'b0);
        tbl[2]  = mk(8'b1100_0100, 4'b1101, 2, 0, 0, 0, 1'b0);
        tbl[3]  = mk(8'b1100_0100, 4'b1101, 3, 0, 0, 0, 1'b0);
        tbl[4]  = mk(8'b1100_0100, 4'b0001, 4, 0, 0, 0, 1'b0);
        tbl[5]  = mk(8'b1100_0100, 4'b0001, 4, 0, 1, 0, 1'b0);
        tbl[6]  = mk(8'b1111_0100, 4'b0001, 4, 0, 2, 0, 1'b0);
        tbl[7]  = mk(8'b1100_0100, 4'b1101, 3, 0, 3, 0, 1'b0);
        tbl[8]  = mk(8'b0100_0100, 4'b0001, 4, 0, 3, 0, 1'b0);
        tbl[9]  = mk(8'b0111_0100, 4'b0001, 4, 0, 3, 0, 1'b0);
        tbl[10] = mk(8'b0111_0100, 4'b0101, 3, 0, 3, 0, 1'b0);
        tbl[11] = mk(8'b1111_0100, 4'b1101, 2, 0, 3, 0, 1'b0);
        tbl[12] = mk(8'b0110_0100, 4'b0101, 2, 0, 3, 0, 1'b0);
        tbl[13] = mk(8'b0100_0100, 4'b0101, 2, 0, 3, 0, 1'b0);
        tbl[14] = mk(8'b0100_1110, 4'b0111, 2, 0, 3, 0, 1'b0);
        tbl[15] = mk(8'b0100_1110, 4'b0100, 2, 1, 3, 0, 1'b0);
        tbl[16] = mk(8'b0100_1110, 4'b0100, 2, 1, 3, 1, 1'b0);
        tbl[17] = mk(8'b0100_1101, 4'b0100, 2, 1, 3, 2, 1'b0);
        tbl[18] = mk(8'b0100_1100, 4'b0111, 2, 0, 3, 3, 1'b0);
        tbl[19] = mk(8'b0100_0100, 4'b0100, 2, 1, 3, 3, 1'b0);
        tbl[20] = mk(8'b0100_0101, 4'b0100, 2, 1, 3, 3, 1'b0);
        tbl[21] = mk(8'b0100_0100, 4'b0101, 2, 0, 3, 3, 1'b0);
        tbl[22] = mk(8'b0100_0101, 4'b0101, 2, 0, 3, 3, 1'b0);
        tbl[23] = mk(8'b0100_0100, 4'b0101, 2, 0, 3, 3, 1'b1);
        tbl[24] = mk(8'b0100_1101, 4'b0111, 2, 0, 3, 3, 1'b1);
        tbl[25] = mk(8'b0100_0100, 4'b0101, 2, 0, 3, 3, 1'b1);

        // reset state, sampled while aresetn is low
        #2;
        chk("rst_rd_out", rd_outstanding, 0);
        chk("rst_wr_out", wr_outstanding, 0);
        chk("rst_err", err_underflow, 0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge aclk);
            drive(tbl[i].stim);
            #1;
            chk($sformatf("v%0d_m_arvalid", i), m_axi_arvalid, tbl[i].eo[3]);
            chk($sformatf("v%0d_s_arready", i), s_axi_arready, tbl[i].eo[2]);
            chk($sformatf("v%0d_m_awvalid", i), m_axi_awvalid, tbl[i].eo[1]);
            chk($sformatf("v%0d_s_awready", i), s_axi_awready, tbl[i].eo[0]);
            chk($sformatf("v%0d_m_wvalid", i), m_axi_wvalid, tbl[i].stim[1]);
            chk($sformatf("v%0d_rd_out", i), rd_outstanding, tbl[i].rd);
            chk($sformatf("v%0d_wr_out", i), wr_outstanding, tbl[i].wr);
            chk($sformatf("v%0d_rd_stall", i), rd_stall_cycles, tbl[i].rdst);
            chk($sformatf("v%0d_wr_stall", i), wr_stall_cycles, tbl[i].wrst);
            chk($sformatf("v%0d_err", i), err_underflow, tbl[i].err);
        end

        // one more read to reach rd_cnt=3, checking payload passthrough on the way
        @(negedge aclk);
        drive(8'b1100_0110);
        m_axi_bvalid = 1'b0;
        #1;
        chk("pt_araddr", m_axi_araddr, 32'h1000_0040);
        chk("pt_arid", m_axi_arid, 4'h3);
        chk("pt_awaddr", m_axi_awaddr, 32'h2000_0080);
        chk("pt_wdata", m_axi_wdata, 64'h0011_2233_4455_6677);
        chk("pt_rdata", s_axi_rdata, 64'hDEAD_BEEF_0123_4567);
        chk("pt_rid", s_axi_rid, 4'h5);
        chk("pt_bresp", s_axi_bresp, 2'b10);
        chk("pt_wready", s_axi_wready, 1'b1);
        @(negedge aclk);
        drive(8'b0100_0100);
        #1;
        chk("pre_rst_rd_out", rd_outstanding, 3);

        // asynchronous reset between edges: status clears without a clock edge
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        chk("arst_rd_out", rd_outstanding, 0);
        chk("arst_wr_out", wr_outstanding, 0);
        chk("arst_rd_stall", rd_stall_cycles, 0);
        chk("arst_wr_stall", wr_stall_cycles, 0);
        chk("arst_err", err_underflow, 0);
        chk("arst_s_arready", s_axi_arready, 1'b1);
        chk("arst_def_rd_out", d2_rd_out, 0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        // late response to a pre-reset burst counts as underflow
        @(negedge aclk);
        drive(8'b0111_0100);
        @(negedge aclk);
        drive(8'b0100_0100);
        #1;
        chk("late_r_rd_out", rd_outstanding, 0);
        chk("late_r_err", err_underflow, 1'b1);
        chk("late_r_def_err", d2_err, 1'b1);

        hs1 = 0;
        hs2 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            drive(8'b1100_0100);
            #1;
            hs1 += int'(m_axi_arvalid & m_axi_arready);
            hs2 += int'(d2_m_arvalid & m_axi_arready);
        end
        @(negedge aclk);
        drive(8'b0100_0100);
        #1;
        chk("post_rst_hs_lim4", hs1, 4);
        chk("post_rst_hs_def", hs2, 8);
        chk("post_rst_rd_out_lim4", rd_outstanding, 4);
        chk("post_rst_rd_out_def", d2_rd_out, 8);
        chk("post_rst_def_arready", d2_s_arready, 1'b0);
        chk("post_rst_stall_lim4", rd_stall_cycles, 6);
        chk("post_rst_stall_def", d2_rd_stall, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
